// File: rtl/ysyx_25040111_wbu_if.sv
// ysyx_25040111_wbu_if: EXU result, memory read response and register-file write bundle around the writeback unit
// Signals:
//   in_valid/in_ready                  EXU -> WBU handshake
//   in_rd/in_rd_wen/in_is_load         destination register, write flag, load flag
//   in_funct3/in_addr_lo/in_alu_res    load type, load address low bits, ALU result
//   mem_rvalid/mem_rready              memory read response handshake
//   mem_rdata/mem_rresp                raw response word and status (00 = OKAY)
//   rf_wen/rf_waddr/rf_wdata           register file write port
//   commit/load_err                    retire pulse and load-fault pulse
// Modports: master = EXU/memory/register-file side, slave = writeback unit.
interface ysyx_25040111_wbu_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_res;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit;
  logic        load_err;
  modport master (
    output in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_alu_res,
    output mem_rvalid, mem_rdata, mem_rresp,
    input  in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, commit, load_err
  );
  modport slave (
    input  in_valid, in_rd, in_rd_wen, in_is_load, in_funct3, in_addr_lo, in_alu_res,
    input  mem_rvalid, mem_rdata, mem_rresp,
    output in_ready, mem_rready, rf_wen, rf_waddr, rf_wdata, commit, load_err
  );
endinterface

// File: rtl/ysyx_25040111_wbu.sv
// ysyx_25040111_wbu: writeback unit that retires EXU results and aligned load data into the register file
// Ports:
//   clock    system clock, all state updates on posedge
//   reset_n  synchronous active-low reset
//   io       ysyx_25040111_wbu_if.slave (EXU handshake, memory response, register-file write, commit/load_err)
// The write-port outputs come straight from registers, so the WRITE cycle
// has no combinational path from any input.
module ysyx_25040111_wbu (
  input logic                    clock,
  input logic                    reset_n,
  ysyx_25040111_wbu_if.slave     io
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  rd_q, rd_d;
  logic        rd_wen_q, rd_wen_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        rf_wen_q, rf_wen_d;
  logic [3:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        commit_q, commit_d;
  logic        load_err_q, load_err_d;
  logic        in_rdy;
  logic        accept;
  logic        mem_hs;
  logic        bad_f3;
  logic        err;
  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  assign in_rdy  = (state_q != WAIT_MEM);
  assign accept  = io.in_valid & in_rdy;
  assign mem_hs  = (state_q == WAIT_MEM) & io.mem_rvalid;
  assign shifted = io.mem_rdata >> {addr_lo_q, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = addr_lo_q[1] ? io.mem_rdata[31:16] : io.mem_rdata[15:0];
  always_comb begin
    bad_f3    = 1'b0;
    load_data = 32'h0;
    case (funct3_q)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b010:  load_data = io.mem_rdata;
      3'b100:  load_data = {24'h0, byte_v};
      3'b101:  load_data = {16'h0, half_v};
      default: bad_f3 = 1'b1;
    endcase
  end
  assign err = (io.mem_rresp != 2'b00) | bad_f3;
  // Accept and memory handshake are mutually exclusive (accept needs
  // in_ready, which is low in WAIT_MEM), so they never fight over the
  // write-port registers.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    commit_d   = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      IDLE, WRITE: state_d = accept ? (io.in_is_load ? WAIT_MEM : WRITE) : IDLE;
      WAIT_MEM:    state_d = mem_hs ? WRITE : WAIT_MEM;
      default:     state_d = IDLE;
    endcase
    if (accept) begin
      rd_d      = io.in_rd;
      rd_wen_d  = io.in_rd_wen;
      funct3_d  = io.in_funct3;
      addr_lo_d = io.in_addr_lo;
      if (!io.in_is_load) begin
        rf_wen_d   = io.in_rd_wen & (io.in_rd != 4'd0);
        rf_waddr_d = io.in_rd;
        rf_wdata_d = io.in_alu_res;
        commit_d   = 1'b1;
      end
    end
    if (mem_hs) begin
      rf_wen_d   = rd_wen_q & (rd_q != 4'd0) & ~err;
      rf_waddr_d = rd_q;
      rf_wdata_d = load_data;
      commit_d   = 1'b1;
      load_err_d = err;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_q       <= 4'd0;
      rd_wen_q   <= 1'b0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 4'd0;
      rf_wdata_q <= 32'd0;
      commit_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      funct3_q   <= funct3_d;
      addr_lo_q  <= addr_lo_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      commit_q   <= commit_d;
      load_err_q <= load_err_d;
    end
  end
  assign io.in_ready   = in_rdy;
  assign io.mem_rready = (state_q == WAIT_MEM);
  assign io.rf_wen     = rf_wen_q;
  assign io.rf_waddr   = rf_waddr_q;
  assign io.rf_wdata   = rf_wdata_q;
  assign io.commit     = commit_q;
  assign io.load_err   = load_err_q;
endmodule

// File: tb/tb_ysyx_25040111_wbu.sv
// tb_ysyx_25040111_wbu: directed vector table, reset corner case and random traffic against a transaction-level model
module tb_ysyx_25040111_wbu;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  ysyx_25040111_wbu_if bus();
  ysyx_25040111_wbu dut (.clock(clock), .reset_n(reset_n), .io(bus));
  typedef struct {
    logic        v;
    logic [3:0]  rd;
    logic        w;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  al;
    logic [31:0] alu;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        e_rdy;
    logic        e_wen;
    logic        e_c;
    logic        e_err;
    logic [3:0]  e_addr;
    logic [31:0] e_data;
    logic        e_dk;
  } vec_t;
  vec_t tv[$];
  int total = 0;
  int bad = 0;
  // Model: only remembers whether a load is outstanding plus the op it belongs to.
  logic        m_busy;
  logic [3:0]  m_rd;
  logic        m_w;
  logic [2:0]  m_f3;
  logic [1:0]  m_al;
  logic        e_wen, e_c, e_err, e_dk;
  logic [3:0]  e_addr;
  logic [31:0] e_data;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic add(input logic v, input logic [3:0] rd, input logic w, input logic ld,
                     input logic [2:0] f3, input logic [1:0] al, input logic [31:0] alu,
                     input logic rv, input logic [31:0] rdata, input logic [1:0] resp,
                     input logic e_rdy_i, input logic e_wen_i, input logic e_c_i, input logic e_err_i,
                     input logic [3:0] e_addr_i, input logic [31:0] e_data_i, input logic e_dk_i);
    vec_t t;
    t.v = v; t.rd = rd; t.w = w; t.ld = ld; t.f3 = f3; t.al = al; t.alu = alu;
    t.rv = rv; t.rdata = rdata; t.resp = resp;
    t.e_rdy = e_rdy_i; t.e_wen = e_wen_i; t.e_c = e_c_i; t.e_err = e_err_i;
    t.e_addr = e_addr_i; t.e_data = e_data_i; t.e_dk = e_dk_i;
    tv.push_back(t);
  endtask
  // Load value by arithmetic on the byte/halfword numeric value.
  function automatic logic [32:0] ld_val(input logic [2:0] f3, input logic [1:0] al, input logic [31:0] rdata);
    int unsigned b, h;
    b = (rdata >> (8 * al)) & 32'd255;
    h = (al >= 2) ? (rdata >> 16) : (rdata & 32'd65535);
    case (f3)
      3'd0:    return {1'b0, (b >= 128) ? b - 32'd256 : b};
      3'd1:    return {1'b0, (h >= 32768) ? h - 32'd65536 : h};
      3'd2:    return {1'b0, rdata};
      3'd4:    return {1'b0, b};
      3'd5:    return {1'b0, h};
      default: return {1'b1, 32'd0};
    endcase
  endfunction
  task automatic model_step();
    logic [32:0] r;
    logic        er;
    e_wen = 1'b0; e_c = 1'b0; e_err = 1'b0;
    if (!reset_n) begin
      m_busy = 1'b0; m_rd = 0; m_w = 0; m_f3 = 0; m_al = 0;
      e_addr = 4'd0; e_data = 32'd0; e_dk = 1'b1;
    end else if (m_busy) begin
      if (bus.mem_rvalid) begin
        r = ld_val(m_f3, m_al, bus.mem_rdata);
        er = r[32] || (bus.mem_rresp != 2'b00);
        m_busy = 1'b0;
        e_c = 1'b1; e_err = er; e_wen = m_w && (m_rd != 0) && !er;
        e_addr = m_rd; e_data = r[31:0]; e_dk = !r[32];
      end
    end else if (bus.in_valid) begin
      if (bus.in_is_load) begin
        m_busy = 1'b1; m_rd = bus.in_rd; m_w = bus.in_rd_wen; m_f3 = bus.in_funct3; m_al = bus.in_addr_lo;
      end else begin
        e_c = 1'b1; e_wen = bus.in_rd_wen && (bus.in_rd != 0);
        e_addr = bus.in_rd; e_data = bus.in_alu_res; e_dk = 1'b1;
      end
    end
  endtask
  task automatic check_model();
    chk("m_in_ready", {31'd0, bus.in_ready}, {31'd0, !m_busy});
    chk("m_mem_rready", {31'd0, bus.mem_rready}, {31'd0, m_busy});
    chk("m_rf_wen", {31'd0, bus.rf_wen}, {31'd0, e_wen});
    chk("m_commit", {31'd0, bus.commit}, {31'd0, e_c});
    chk("m_load_err", {31'd0, bus.load_err}, {31'd0, e_err});
    chk("m_rf_waddr", {28'd0, bus.rf_waddr}, {28'd0, e_addr});
    if (e_dk) chk("m_rf_wdata", bus.rf_wdata, e_data);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clock);
    #1;
    check_model();
  endtask
  task automatic idle_in();
    bus.in_valid = 0; bus.in_rd = 0; bus.in_rd_wen = 0; bus.in_is_load = 0;
    bus.in_funct3 = 0; bus.in_addr_lo = 0; bus.in_alu_res = 0;
    bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.mem_rresp = 0;
  endtask
  initial begin
    idle_in();
    // v rd w ld f3 al alu rv rdata resp | rdy wen c err addr data dk
    add(1, 5, 1, 0, 0, 0, 32'h12345678, 0, 0, 0,            1, 1, 1, 0, 5, 32'h12345678, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 5, 32'h12345678, 1);
    add(1, 3, 1, 1, 0, 3, 0, 0, 0, 0,                        0, 0, 0, 0, 5, 32'h12345678, 1);
    add(1, 15, 1, 0, 0, 0, 32'hDEAD, 0, 0, 0,                0, 0, 0, 0, 5, 32'h12345678, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h80AABBCC, 0,             1, 1, 1, 0, 3, 32'hFFFFFF80, 1);
    add(1, 4, 1, 1, 5, 2, 0, 0, 0, 0,                        0, 0, 0, 0, 3, 32'hFFFFFF80, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF0001, 0,             1, 1, 1, 0, 4, 32'h0000BEEF, 1);
    add(1, 6, 1, 1, 1, 2, 0, 0, 0, 0,                        0, 0, 0, 0, 4, 32'h0000BEEF, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF0001, 0,             1, 1, 1, 0, 6, 32'hFFFFBEEF, 1);
    add(1, 0, 1, 0, 0, 0, 32'hAAAA, 0, 0, 0,                 1, 0, 1, 0, 0, 32'hAAAA, 1);
    add(1, 7, 0, 0, 0, 0, 32'hBBBB, 0, 0, 0,                 1, 0, 1, 0, 7, 32'hBBBB, 1);
    add(1, 1, 1, 0, 0, 0, 32'h11, 0, 0, 0,                   1, 1, 1, 0, 1, 32'h11, 1);
    add(1, 2, 1, 0, 0, 0, 32'h22, 0, 0, 0,                   1, 1, 1, 0, 2, 32'h22, 1);
    add(1, 3, 1, 0, 0, 0, 32'h33, 0, 0, 0,                   1, 1, 1, 0, 3, 32'h33, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 3, 32'h33, 1);
    add(1, 8, 1, 1, 2, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 3, 32'h33, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 2,             1, 0, 1, 1, 8, 32'hCAFEF00D, 1);
    add(1, 9, 1, 1, 3, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 8, 32'hCAFEF00D, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0,             1, 0, 1, 1, 9, 32'h0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                        1, 0, 0, 0, 9, 32'h0, 0);
    reset_n = 0;
    cyc();
    cyc();
    chk("reset_waddr", {28'd0, bus.rf_waddr}, 32'd0);
    chk("reset_wdata", bus.rf_wdata, 32'd0);
    reset_n = 1;
    foreach (tv[i]) begin
      bus.in_valid = tv[i].v; bus.in_rd = tv[i].rd; bus.in_rd_wen = tv[i].w; bus.in_is_load = tv[i].ld;
      bus.in_funct3 = tv[i].f3; bus.in_addr_lo = tv[i].al; bus.in_alu_res = tv[i].alu;
      bus.mem_rvalid = tv[i].rv; bus.mem_rdata = tv[i].rdata; bus.mem_rresp = tv[i].resp;
      cyc();
      chk($sformatf("row%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tv[i].e_rdy});
      chk($sformatf("row%0d_mem_rready", i), {31'd0, bus.mem_rready}, {31'd0, !tv[i].e_rdy});
      chk($sformatf("row%0d_rf_wen", i), {31'd0, bus.rf_wen}, {31'd0, tv[i].e_wen});
      chk($sformatf("row%0d_commit", i), {31'd0, bus.commit}, {31'd0, tv[i].e_c});
      chk($sformatf("row%0d_load_err", i), {31'd0, bus.load_err}, {31'd0, tv[i].e_err});
      chk($sformatf("row%0d_rf_waddr", i), {28'd0, bus.rf_waddr}, {28'd0, tv[i].e_addr});
      if (tv[i].e_dk) chk($sformatf("row%0d_rf_wdata", i), bus.rf_wdata, tv[i].e_data);
    end
    // Reset while a load waits for memory; the late response must be dropped.
    idle_in();
    bus.in_valid = 1; bus.in_rd = 10; bus.in_rd_wen = 1; bus.in_is_load = 1; bus.in_funct3 = 2;
    cyc();
    idle_in();
    cyc();
    chk("rst_wait_mem_rready", {31'd0, bus.mem_rready}, 32'd1);
    reset_n = 0;
    cyc();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h55AA55AA;
    cyc();
    chk("rst_late_rvalid_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_late_rvalid_commit", {31'd0, bus.commit}, 32'd0);
    chk("rst_late_rvalid_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_late_rvalid_waddr", {28'd0, bus.rf_waddr}, 32'd0);
    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] f3s[6];
      f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_rd = 4'($urandom_range(0, 15));
      bus.in_rd_wen = ($urandom_range(0, 4) != 0);
      bus.in_is_load = ($urandom_range(0, 9) < 4);
      bus.in_funct3 = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : f3s[$urandom_range(0, 4)];
      bus.in_addr_lo = 2'($urandom_range(0, 3));
      bus.in_alu_res = $urandom;
      bus.mem_rvalid = $urandom_range(0, 1) == 1;
      bus.mem_rdata = $urandom;
      bus.mem_rresp = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      reset_n = ($urandom_range(0, 99) != 0);
      cyc();
    end
    reset_n = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
